// File: rtl/ff_pkg.sv
// Shared pointer types and binary/gray conversion helpers for the FIFO pointer logic.
// Narrower pointers are zero-extended into ptr_t and size-cast back after conversion.
package ff_pkg;

   localparam int MAX_PTR_W = 15;

   typedef logic [MAX_PTR_W:0] ptr_t;

   function automatic ptr_t bin2gry(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gry2bin(input ptr_t g);
      ptr_t b;
      b[MAX_PTR_W] = g[MAX_PTR_W];
      for (int i = MAX_PTR_W - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gry_ptr.sv
// Binary+gray pointer pair with wrap bit; registered outputs update 1 cycle after inc/clr.
// No backpressure: inc must already be qualified by the caller, clr overrides inc.
module gry_ptr
   import ff_pkg::*;
#(
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W:0]   bin,
   output logic [PTR_W:0]   bin_nxt,
   output logic [PTR_W:0]   gry,
   output logic [PTR_W:0]   gry_nxt
);

   localparam int W1 = PTR_W + 1;

   always_comb begin
      bin_nxt = clr ? '0 : bin + W1'(inc);
      gry_nxt = W1'(bin2gry(ptr_t'(bin_nxt)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin <= '0;
         gry <= '0;
      end else begin
         bin <= bin_nxt;
         gry <= gry_nxt;
      end
   end

endmodule

// File: rtl/sync_ff_ptr_ctrl.sv
// Single-clock FIFO pointer controller: acks same cycle, pointers/flags/occ 1 cycle later.
// Writes are refused while full and reads while empty; flush clears both pointers.
module sync_ff_ptr_ctrl
   import ff_pkg::*;
#(
   parameter int PTR_W     = 4,
   parameter int AFULL_TH  = 2**PTR_W - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic             wr_ack,
   output logic             rd_ack,
   output logic [PTR_W-1:0] wr_addr,
   output logic [PTR_W-1:0] rd_addr,
   output logic [PTR_W:0]   wr_ptr_gry,
   output logic [PTR_W:0]   rd_ptr_gry,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [PTR_W:0]   occ,
   output logic             ovrflw,
   output logic             undrflw
);

   localparam int             W1       = PTR_W + 1;
   localparam logic [PTR_W:0] AFULL_V  = W1'(AFULL_TH);
   localparam logic [PTR_W:0] AEMPTY_V = W1'(AEMPTY_TH);

   logic [PTR_W:0] wr_bin, wr_bin_nxt, wr_gry_nxt;
   logic [PTR_W:0] rd_bin, rd_bin_nxt, rd_gry_nxt;
   logic [PTR_W:0] occ_nxt;
   logic           empty_nxt, full_nxt;

   assign wr_ack = wr_en & ~full  & ~flush;
   assign rd_ack = rd_en & ~empty & ~flush;

   gry_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .inc     (wr_ack),
      .bin     (wr_bin),
      .bin_nxt (wr_bin_nxt),
      .gry     (wr_ptr_gry),
      .gry_nxt (wr_gry_nxt)
   );

   gry_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .inc     (rd_ack),
      .bin     (rd_bin),
      .bin_nxt (rd_bin_nxt),
      .gry     (rd_ptr_gry),
      .gry_nxt (rd_gry_nxt)
   );

   assign wr_addr = wr_bin[PTR_W-1:0];
   assign rd_addr = rd_bin[PTR_W-1:0];

   // Full: pointers differ only in the two gray MSBs (wrap bit set apart by one lap).
   always_comb begin
      occ_nxt   = wr_bin_nxt - rd_bin_nxt;
      empty_nxt = (wr_gry_nxt == rd_gry_nxt);
      full_nxt  = (wr_gry_nxt == {~rd_gry_nxt[PTR_W:PTR_W-1], rd_gry_nxt[PTR_W-2:0]});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ          <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         ovrflw       <= 1'b0;
         undrflw      <= 1'b0;
      end else begin
         occ          <= occ_nxt;
         empty        <= empty_nxt;
         full         <= full_nxt;
         almost_full  <= (occ_nxt >= AFULL_V);
         almost_empty <= (occ_nxt <= AEMPTY_V);
         ovrflw       <= wr_en & full;
         undrflw      <= rd_en & empty;
      end
   end

   // Exported gray pointers must always be the exact encoding of the binary pointers.
   wr_gry_consistent: assert property (@(posedge clk) disable iff (!rst_n)
      wr_ptr_gry == W1'(bin2gry(ptr_t'(wr_bin))));
   rd_gry_consistent: assert property (@(posedge clk) disable iff (!rst_n)
      rd_bin == W1'(gry2bin(ptr_t'(rd_ptr_gry))));

endmodule

// File: tb/tb_sync_ff_ptr_ctrl.sv
// Directed bench for sync_ff_ptr_ctrl at depth 4 (PTR_W=2, AFULL_TH=3, AEMPTY_TH=1).
module tb_sync_ff_ptr_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush, wr_en, rd_en;
   logic       wr_ack, rd_ack;
   logic [1:0] wr_addr, rd_addr;
   logic [2:0] wr_ptr_gry, rd_ptr_gry;
   logic       full, empty, almost_full, almost_empty;
   logic [2:0] occ;
   logic       ovrflw, undrflw;

   int checks = 0;
   int errors = 0;

   sync_ff_ptr_ctrl #(.PTR_W(2), .AFULL_TH(3), .AEMPTY_TH(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .wr_ack       (wr_ack),
      .rd_ack       (rd_ack),
      .wr_addr      (wr_addr),
      .rd_addr      (rd_addr),
      .wr_ptr_gry   (wr_ptr_gry),
      .rd_ptr_gry   (rd_ptr_gry),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .occ          (occ),
      .ovrflw       (ovrflw),
      .undrflw      (undrflw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [2:0] g3(input logic [2:0] b);
      return b ^ (b >> 1);
   endfunction

   initial begin
      logic [2:0] wexp [4];
      logic [2:0] wb, rb, prev_w, prev_r;
      wexp = '{3'b001, 3'b011, 3'b010, 3'b110};

      rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      #12;
      chk("rst_occ", 32'(occ), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_aempty", 32'(almost_empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_afull", 32'(almost_full), 0);
      chk("rst_wgry", 32'(wr_ptr_gry), 0);
      chk("rst_rgry", 32'(rd_ptr_gry), 0);
      chk("rst_waddr", 32'(wr_addr), 0);
      chk("rst_raddr", 32'(rd_addr), 0);
      chk("rst_ovr", 32'(ovrflw), 0);
      chk("rst_und", 32'(undrflw), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Read from empty
      rd_en = 1'b1;
      #1;
      chk("und_rd_ack", 32'(rd_ack), 0);
      chk("und_wr_ack", 32'(wr_ack), 0);
      step();
      chk("und_pulse", 32'(undrflw), 1);
      chk("und_occ", 32'(occ), 0);
      chk("und_rgry", 32'(rd_ptr_gry), 0);
      rd_en = 1'b0;
      step();
      chk("und_clear", 32'(undrflw), 0);

      // Fill to full
      for (int k = 0; k < 4; k++) begin
         wr_en = 1'b1;
         #1;
         chk("fill_wr_ack", 32'(wr_ack), 1);
         chk("fill_waddr", 32'(wr_addr), 32'(k));
         step();
         chk("fill_occ", 32'(occ), 32'(k + 1));
         chk("fill_wgry", 32'(wr_ptr_gry), 32'(wexp[k]));
         chk("fill_afull", 32'(almost_full), (k + 1 >= 3) ? 1 : 0);
         chk("fill_full", 32'(full), (k == 3) ? 1 : 0);
         chk("fill_aempty", 32'(almost_empty), (k == 0) ? 1 : 0);
         chk("fill_empty", 32'(empty), 0);
      end

      // Full with simultaneous write and read
      wr_en = 1'b1; rd_en = 1'b1;
      #1;
      chk("full_wr_ack", 32'(wr_ack), 0);
      chk("full_rd_ack", 32'(rd_ack), 1);
      chk("full_raddr", 32'(rd_addr), 0);
      step();
      chk("full_ovr", 32'(ovrflw), 1);
      chk("full_occ", 32'(occ), 3);
      chk("full_full", 32'(full), 0);
      chk("full_afull", 32'(almost_full), 1);
      chk("full_rgry", 32'(rd_ptr_gry), 3'b001);
      chk("full_wgry", 32'(wr_ptr_gry), 3'b110);

      wr_en = 1'b0;
      step();
      chk("rd1_ovr", 32'(ovrflw), 0);
      chk("rd1_occ", 32'(occ), 2);
      chk("rd1_rgry", 32'(rd_ptr_gry), 3'b011);
      chk("rd1_afull", 32'(almost_full), 0);

      // Streaming at occ=2 across the pointer wrap
      wb = 3'd4; rb = 3'd2;
      prev_w = wr_ptr_gry; prev_r = rd_ptr_gry;
      wr_en = 1'b1; rd_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         wb = wb + 3'd1;
         rb = rb + 3'd1;
         chk("strm_occ", 32'(occ), 2);
         chk("strm_wbits", 32'($countones(wr_ptr_gry ^ prev_w)), 1);
         chk("strm_rbits", 32'($countones(rd_ptr_gry ^ prev_r)), 1);
         chk("strm_wgry", 32'(wr_ptr_gry), 32'(g3(wb)));
         chk("strm_rgry", 32'(rd_ptr_gry), 32'(g3(rb)));
         prev_w = wr_ptr_gry; prev_r = rd_ptr_gry;
      end
      chk("strm_waddr", 32'(wr_addr), 0);
      chk("strm_raddr", 32'(rd_addr), 2);
      chk("strm_flags", 32'({full, empty, almost_full, almost_empty}), 0);

      // Flush at occ=3 with a pending write
      rd_en = 1'b0;
      step();
      chk("pre_flush_occ", 32'(occ), 3);
      flush = 1'b1;
      #1;
      chk("flush_wr_ack", 32'(wr_ack), 0);
      step();
      flush = 1'b0; wr_en = 1'b0;
      chk("flush_wgry", 32'(wr_ptr_gry), 0);
      chk("flush_rgry", 32'(rd_ptr_gry), 0);
      chk("flush_waddr", 32'(wr_addr), 0);
      chk("flush_occ", 32'(occ), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_aempty", 32'(almost_empty), 1);
      chk("flush_full", 32'(full), 0);
      chk("flush_afull", 32'(almost_full), 0);

      // Empty with simultaneous write and read
      wr_en = 1'b1; rd_en = 1'b1;
      #1;
      chk("emp_wr_ack", 32'(wr_ack), 1);
      chk("emp_rd_ack", 32'(rd_ack), 0);
      step();
      chk("emp_und", 32'(undrflw), 1);
      chk("emp_occ", 32'(occ), 1);
      chk("emp_empty", 32'(empty), 0);
      chk("emp_aempty", 32'(almost_empty), 1);
      rd_en = 1'b0;
      step();
      wr_en = 1'b0;
      chk("w2_occ", 32'(occ), 2);
      chk("w2_und", 32'(undrflw), 0);
      chk("w2_aempty", 32'(almost_empty), 0);

      // Asynchronous reset between clock edges at occ=2
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_occ", 32'(occ), 0);
      chk("arst_empty", 32'(empty), 1);
      chk("arst_aempty", 32'(almost_empty), 1);
      chk("arst_wgry", 32'(wr_ptr_gry), 0);
      chk("arst_waddr", 32'(wr_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_occ", 32'(occ), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
